request_encoder32: RTL and testbench
====================================

# request_encoder32

Sequential 32-to-5 priority encoder with sticky request capture and a valid/ack handshake. It is the inverse of the 5-to-32 one-hot select decoder used in the processor. Up to 32 single-bit request lines (interrupt/event sources, one per register-slot index) are latched into a pending register. The lowest-numbered pending request is presented as a 5-bit index to a consumer, which acknowledges it; the acknowledged bit is then cleared.

## Interface
- No parameters; width fixed at 32 requests / 5-bit index.
- clock  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req  input  32  request lines; any bit high at a rising edge sets the matching pending bit (level or pulse).
- enable  input  1  capture enable; when low, `req` is ignored and pending bits are retained.
- ack  input  1  consumer accepts the presented index; meaningful only while `valid`=1.
- index  output  5  encoded position of the presented request; stable while `valid`=1 and `ack`=0.
- valid  output  1  `index` holds a pending request.
- pending  output  32  current pending register, for status/debug.

## Operation
- Pending register update at each rising edge:
  - pending_next = (pending & ~clr) | (enable ? req : 0).
  - clr = onehot(index) when `valid`&`ack`, else 0.
  - Set wins: a request arriving on the same bit in the same cycle it is acked is re-pended, not lost.
- Priority: lowest bit number wins (bit 0 highest priority). pe(x) is the index of the least-significant 1 in x, or 0 if x = 0.
- Two-state FSM, registered outputs:
  - IDLE (`valid`=0):
    - If pending != 0: load index <= pe(pending), valid <= 1, go to PRESENT.
    - Otherwise stay.
  - PRESENT (`valid`=1):
    - If `ack`=0: hold `index`; no preemption by newly arriving higher-priority requests.
    - If `ack`=1: let m = pending & ~onehot(index). If m != 0, index <= pe(m) and stay in PRESENT (back-to-back grant). Else valid <= 0, index <= 0, go to IDLE.
- `ack` while `valid`=0 is ignored: no clear, no state change.
- `index` is driven to 0 whenever `valid`=0.

## Timing
- Reset values: pending=0, index=0, valid=0, state=IDLE.
- Reset is asynchronous; outputs drop to reset values without a clock edge. Reset mid-PRESENT discards all pending requests. The first capture happens at the first edge after reset deasserts.
- Request-to-valid latency: `req` high at edge k sets pending at edge k; `valid`/`index` update at edge k+1 (2 edges end-to-end from IDLE).
- Ack-to-next-grant: zero bubble.
  - A request already pending at the ack edge is presented at that same edge.
  - A request arriving in the ack cycle is presented one edge later, via IDLE.
- Throughput: one grant per cycle with `ack` held high.
- Pending vs. presented bit: the bit for the currently presented index stays set in `pending` until its ack edge.
- All 32 bits pending simultaneously is legal: grants proceed 0..31 in order.
- The pending register cannot overflow. A repeated request on an already-pending bit merges into that bit, giving one grant.

## Test plan
- Reset:
  - Assert `reset` mid-cycle with `valid`=1 and pending=0x0000_00F0.
  - Required: valid=0, index=0, pending=0 immediately, before the next edge.
  - After deassert with req=0: outputs remain 0.
- Single request:
  - Pulse req=0x0000_0020 for one cycle, ack=0.
  - Required: two edges later valid=1, index=5. Held for 10 cycles.
  - Ack for one cycle: the next edge gives valid=0, index=0, pending=0.
- Multiple requests, back-to-back:
  - req=0x8000_0011 for one cycle, ack held high.
  - Required: index sequence 0, 4, 31 on three consecutive edges with valid=1, then valid=0 and pending=0.
- No preemption:
  - While index=9 is presented, pulse req bit 2.
  - Required: index stays 9 until ack; at the ack edge index=2.
- Simultaneous ack and re-request:
  - Index 7 presented; in the same cycle assert ack=1 and req=0x80.
  - Required: pending[7] remains 1; valid=0 for one edge, then index=7 again.
- Enable gating:
  - enable=0 with req=0xFFFF_FFFF for 5 cycles.
  - Required: pending and valid unchanged (still 0).
  - Set enable=1: two edges later valid=1, index=0.

Source files
------------

// File: rtl/request_encoder32_if.sv
// request_encoder32_if: request capture and valid/ack grant bus for the 32-to-5 request encoder
interface request_encoder32_if;
    logic [31:0] req;
    logic        enable;
    logic        ack;
    logic [4:0]  index;
    logic        valid;
    logic [31:0] pending;

    modport master (output req, enable, ack, input index, valid, pending);
    modport slave  (input req, enable, ack, output index, valid, pending);
endinterface

// File: rtl/request_encoder32.sv
// request_encoder32: sticky 32-line request capture with lowest-index-first grants over valid/ack
module request_encoder32 (
    input logic                clock,
    input logic                reset,
    request_encoder32_if.slave bus
);
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t      state, state_next;
    logic [31:0] pending, pending_next, onehot, clr, masked;
    logic [4:0]  index, index_next;

    function automatic logic [4:0] pe(input logic [31:0] x);
        logic [4:0] r;
        r = '0;
        for (int i = 31; i >= 0; i--)
            if (x[i]) r = 5'(i);
        return r;
    endfunction

    // Pending update and grant selection; set beats clear so a same-cycle re-request is kept
    always_comb begin
        onehot       = 32'd1 << index;
        clr          = (state == PRESENT && bus.ack) ? onehot : '0;
        pending_next = (pending & ~clr) | (bus.enable ? bus.req : '0);
        masked       = pending & ~onehot;
        state_next   = state;
        index_next   = index;
        if (state == IDLE) begin
            state_next = (pending != '0) ? PRESENT : IDLE;
            index_next = (pending != '0) ? pe(pending) : '0;
        end else if (bus.ack) begin
            state_next = (masked != '0) ? PRESENT : IDLE;
            index_next = (masked != '0) ? pe(masked) : '0;
        end
    end

    // State, presented index and pending register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            index   <= '0;
            pending <= '0;
        end else begin
            state   <= state_next;
            index   <= index_next;
            pending <= pending_next;
        end
    end

    assign bus.index   = index;
    assign bus.valid   = (state == PRESENT);
    assign bus.pending = pending;
endmodule

// File: tb/tb_request_encoder32.sv
// tb_request_encoder32: scoreboard-driven checks of capture, priority, handshake and reset
module tb_request_encoder32;
    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   q[$];
    int   exp_idx;

    request_encoder32_if bus ();

    request_encoder32 dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pop_check(input string name);
        n_checks++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: grant index=%0d seen but scoreboard empty", name, bus.index);
        end else begin
            exp_idx = q.pop_front();
            if (!bus.valid || bus.index !== 5'(exp_idx)) begin
                n_fail++;
                $display("FAIL %s: valid=%0b index=%0d, required valid=1 index=%0d", name, bus.valid, bus.index, exp_idx);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.req = '0; bus.enable = 1'b1; bus.ack = 1'b0;
        step(); step();
        n_checks++;
        if (bus.valid !== 1'b0 || bus.index !== 5'd0 || bus.pending !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_initial: valid=%0b index=%0d pending=%h, required 0/0/0", bus.valid, bus.index, bus.pending);
        end
        reset = 1'b0;
        bus.req = 32'h0000_00F0;
        step();
        bus.req = '0;
        step();
        n_checks++;
        if (bus.valid !== 1'b1 || bus.index !== 5'd4 || bus.pending !== 32'h0000_00F0) begin
            n_fail++;
            $display("FAIL reset_setup: valid=%0b index=%0d pending=%h, required 1/4/000000f0", bus.valid, bus.index, bus.pending);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.valid !== 1'b0 || bus.index !== 5'd0 || bus.pending !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_async: valid=%0b index=%0d pending=%h, required 0/0/0", bus.valid, bus.index, bus.pending);
        end
        step();
        reset = 1'b0;
        bus.ack = 1'b1;
        step(); step();
        bus.ack = 1'b0;
        n_checks++;
        if (bus.valid !== 1'b0 || bus.index !== 5'd0 || bus.pending !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_release: valid=%0b index=%0d pending=%h, required 0/0/0", bus.valid, bus.index, bus.pending);
        end
    endtask

    task automatic test_single();
        bus.req = 32'h0000_0020;
        q.push_back(5);
        step();
        bus.req = '0;
        n_checks++;
        if (bus.valid !== 1'b0 || bus.pending !== 32'h0000_0020) begin
            n_fail++;
            $display("FAIL single_latency: valid=%0b pending=%h, required 0/00000020", bus.valid, bus.pending);
        end
        step();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (bus.valid !== 1'b1 || bus.index !== 5'd5) begin
                n_fail++;
                $display("FAIL single_hold%0d: valid=%0b index=%0d, required 1/5", i, bus.valid, bus.index);
            end
            step();
        end
        bus.ack = 1'b1;
        pop_check("single_grant");
        step();
        bus.ack = 1'b0;
        n_checks++;
        if (bus.valid !== 1'b0 || bus.index !== 5'd0 || bus.pending !== 32'd0) begin
            n_fail++;
            $display("FAIL single_cleared: valid=%0b index=%0d pending=%h, required 0/0/0", bus.valid, bus.index, bus.pending);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int cycles = 0;
        bus.ack = 1'b1;
        while (q.size() > 0 && cycles < budget) begin
            if (bus.valid) pop_check(name);
            step();
            cycles++;
        end
        bus.ack = 1'b0;
        n_checks++;
        if (q.size() != 0 || bus.valid !== 1'b0 || bus.pending !== 32'd0) begin
            n_fail++;
            $display("FAIL %s_end: left=%0d valid=%0b pending=%h, required 0/0/0", name, q.size(), bus.valid, bus.pending);
        end
        q.delete();
    endtask

    task automatic test_back_to_back();
        bus.req = 32'h8000_0011;
        bus.ack = 1'b1;
        q.push_back(0); q.push_back(4); q.push_back(31);
        step();
        bus.req = '0;
        step();
        n_checks++;
        if (bus.valid !== 1'b1 || bus.index !== 5'd0) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%0b index=%0d, required 1/0", bus.valid, bus.index);
        end
        for (int i = 0; i < 3; i++) begin
            pop_check("b2b_seq");
            step();
        end
        bus.ack = 1'b0;
        n_checks++;
        if (bus.valid !== 1'b0 || bus.index !== 5'd0 || bus.pending !== 32'd0) begin
            n_fail++;
            $display("FAIL b2b_end: valid=%0b index=%0d pending=%h, required 0/0/0", bus.valid, bus.index, bus.pending);
        end
        q.delete();
    endtask

    task automatic test_no_preempt();
        bus.req = 32'd1 << 9;
        q.push_back(9);
        step();
        bus.req = '0;
        step();
        bus.req = 32'd1 << 2;
        q.push_back(2);
        step();
        bus.req = '0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.valid !== 1'b1 || bus.index !== 5'd9) begin
                n_fail++;
                $display("FAIL nopreempt_hold%0d: valid=%0b index=%0d, required 1/9", i, bus.valid, bus.index);
            end
            step();
        end
        drain("nopreempt", 10);
    endtask

    task automatic test_ack_rerequest();
        bus.req = 32'h80;
        step();
        bus.req = '0;
        step();
        n_checks++;
        if (bus.valid !== 1'b1 || bus.index !== 5'd7) begin
            n_fail++;
            $display("FAIL rereq_setup: valid=%0b index=%0d, required 1/7", bus.valid, bus.index);
        end
        bus.ack = 1'b1;
        bus.req = 32'h80;
        step();
        bus.ack = 1'b0;
        bus.req = '0;
        n_checks++;
        if (bus.pending !== 32'h80 || bus.valid !== 1'b0 || bus.index !== 5'd0) begin
            n_fail++;
            $display("FAIL rereq_kept: pending=%h valid=%0b index=%0d, required 00000080/0/0", bus.pending, bus.valid, bus.index);
        end
        q.push_back(7);
        step();
        drain("rereq", 5);
    endtask

    task automatic test_enable();
        bus.enable = 1'b0;
        bus.req = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (bus.pending !== 32'd0 || bus.valid !== 1'b0) begin
                n_fail++;
                $display("FAIL enable_gated%0d: pending=%h valid=%0b, required 0/0", i, bus.pending, bus.valid);
            end
        end
        bus.enable = 1'b1;
        for (int i = 0; i < 32; i++) q.push_back(i);
        step();
        bus.req = '0;
        step();
        n_checks++;
        if (bus.valid !== 1'b1 || bus.index !== 5'd0 || bus.pending !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL enable_open: valid=%0b index=%0d pending=%h, required 1/0/ffffffff", bus.valid, bus.index, bus.pending);
        end
        drain("all32", 40);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_no_preempt();
        test_ack_rerequest();
        test_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
